// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad scanner
// Purpose: FSM state enum, frame-class enum and the key-code width helper
//          used by keypad_scan_fifo and its testbench.
// Ports:   none (package).
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } frame_class_t;

    // Width of a key code row_idx*cols + col_idx; never narrower than 1 bit.
    function automatic int code_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - synchronous key-event FIFO
// Purpose: single-clock FIFO holding debounced key codes.
//          A push while full is accepted only if a pop happens in the same cycle.
//          dout reads 0 while empty.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, din  write request and data
//   full       no free entry
//   pop        read request; only acts while valid
//   valid      head entry present
//   dout       head entry, 0 when empty
module keypad_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - row-scan keypad front end with debounced event FIFO
// Purpose: drives one-hot rows, samples columns at the end of each row slot,
//          classifies each full frame (none / one key / several keys), debounces
//          press and release, and queues one key code per press.
//          Optional macro KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   col_in     column sense, 1 = key closed on the driven row
//   row_out    one-hot active-high row drive
//   key_valid  FIFO head holds a key event
//   key_code   head code = row_idx*COLS + col_idx
//   key_ready  consumer accepts the head when key_valid && key_ready
//   key_held   debounced key currently down
//   overflow   sticky, an event was dropped on a full FIFO
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEBOUNCE    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COLS-1:0]                col_in,
    output logic [ROWS-1:0]                row_out,
    output logic                           key_valid,
    output logic [code_w(ROWS, COLS)-1:0]  key_code,
    input  logic                           key_ready,
    output logic                           key_held,
    output logic                           overflow
);

    localparam int CW  = code_w(ROWS, COLS);
    localparam int NB  = ROWS * COLS;
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DBW = $clog2(DEBOUNCE + 1);

    // ---------------- scan ----------------
    logic [DW-1:0] div_cnt;
    logic [RW-1:0] row_idx;
    logic [NB-1:0] frame;
    logic          frame_tick;
    logic          slot_end;

    assign slot_end = (div_cnt == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            row_idx    <= '0;
            frame      <= '0;
            frame_tick <= 1'b0;
        end else begin
            // Registered so the FSM sees the snapshot with the last row already stored.
            frame_tick <= slot_end && (row_idx == RW'(ROWS - 1));
            if (slot_end) begin
                div_cnt                       <= '0;
                frame[row_idx*COLS +: COLS]   <= col_in;
                row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        row_out          = '0;
        row_out[row_idx] = 1'b1;
    end

    // ---------------- frame classification ----------------
    frame_class_t fclass;
    logic [CW-1:0] hit_code;
    logic          any_bit;
    logic          multi_bit;

    always_comb begin
        any_bit   = 1'b0;
        multi_bit = 1'b0;
        hit_code  = '0;
        for (int i = 0; i < NB; i++) begin
            if (frame[i]) begin
                if (any_bit) multi_bit = 1'b1;
                any_bit  = 1'b1;
                hit_code = CW'(i);
            end
        end
        if (multi_bit)    fclass = MULTI;
        else if (any_bit) fclass = KEY;
        else              fclass = NONE;
    end

    // ---------------- debounce FSM ----------------
    key_state_t     state, state_n;
    logic [CW-1:0]  cand, cand_n;
    logic [DBW-1:0] cnt, cnt_n;
    logic [DBW-1:0] cnt_inc;
    logic           db_done;
    logic           fsm_push;
    logic           rep_push;
    logic           push_key;

    assign cnt_inc = cnt + 1'b1;
    assign db_done = (cnt_inc >= DBW'(DEBOUNCE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        fsm_push = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (fclass == KEY) begin
                        cand_n = hit_code;
                        cnt_n  = DBW'(1);
                        if (DEBOUNCE == 1) begin
                            fsm_push = 1'b1;
                            state_n  = HELD;
                        end else begin
                            state_n  = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (fclass == KEY && hit_code == cand) begin
                        cnt_n = cnt_inc;
                        if (db_done) begin
                            fsm_push = 1'b1;
                            state_n  = HELD;
                        end
                    end else if (fclass == KEY) begin
                        cand_n = hit_code;
                        cnt_n  = DBW'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (fclass == NONE) begin
                        cnt_n   = DBW'(1);
                        state_n = (DEBOUNCE == 1) ? IDLE : REL_DB;
                    end
                end
                REL_DB: begin
                    if (fclass == NONE) begin
                        cnt_n = cnt_inc;
                        if (db_done) state_n = IDLE;
                    end else begin
                        // A key or a ghost frame means the key never really left.
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign key_held = (state == HELD) || (state == REL_DB);

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int REPW = $clog2(RMAX + 1);

    logic [REPW-1:0] rep_cnt;
    logic            rep_armed;
    logic            rep_step;
    logic            rep_hit;

    // Counts key-down frames in HELD; first target is the delay, then the rate.
    assign rep_step = frame_tick && (state == HELD) && (fclass != NONE);
    assign rep_hit  = ((rep_cnt + 1'b1) ==
                       (rep_armed ? REPW'(REPEAT_RATE) : REPW'(REPEAT_DLY)));
    assign rep_push = rep_step && rep_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (frame_tick) begin
            if (state_n != HELD && state_n != REL_DB) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (rep_step) begin
                if (rep_hit) begin
                    rep_cnt   <= '0;
                    rep_armed <= 1'b1;
                end else begin
                    rep_cnt   <= rep_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DLY, REPEAT_RATE};
    assign rep_push      = 1'b0;
`endif

    assign push_key = fsm_push || rep_push;

    // ---------------- event FIFO ----------------
    logic fifo_full;
    logic pop;

    assign pop = key_valid && key_ready;

    keypad_event_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_key),
        .din   (cand),
        .full  (fifo_full),
        .pop   (pop),
        .valid (key_valid),
        .dout  (key_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_key && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule
